// File: rtl/ofifo_pkg.sv
// ofifo_pkg: shared sizing for the output FIFO bank.
// ofifo, sfu_bank and the core top import these defaults so their buses agree.
// PTR_W is one bit wider than the address so full and empty differ by the MSB.
package ofifo_pkg;
  localparam int COL     = 8;
  localparam int PSUM_BW = 32;
  localparam int DEPTH   = 64;

  function automatic int ptr_w(input int d);
    return $clog2(d) + 1;
  endfunction

  localparam int PTR_W = ptr_w(DEPTH);
endpackage

// File: rtl/ofifo_if.sv
// ofifo_if: handshake/data bundle between the MAC column writers, the row reader
// and ofifo.
//   wr, in, rd      : column write strobes, column data, row pop request
//   out, out_valid  : registered popped row and its one-cycle strobe
//   o_valid/o_full/o_ready/o_overflow : status flags
// master = producer/consumer side, slave = ofifo.
interface ofifo_if
  import ofifo_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW
);
  logic [col-1:0]              wr;
  logic [col-1:0][psum_bw-1:0] in;
  logic                        rd;
  logic [col-1:0][psum_bw-1:0] out;
  logic                        out_valid;
  logic                        o_valid;
  logic                        o_full;
  logic                        o_ready;
  logic                        o_overflow;

  modport master (output wr, in, rd,
                  input  out, out_valid, o_valid, o_full, o_ready, o_overflow);
  modport slave  (input  wr, in, rd,
                  output out, out_valid, o_valid, o_full, o_ready, o_overflow);
endinterface

// File: rtl/ofifo_col_fifo.sv
// col_fifo: one column of the output FIFO bank.
// Owns storage and its write pointer; the read pointer is shared across all
// columns and supplied by the parent, so full/empty are derived against it.
// Ports: clk, reset (sync, active high), wr/data (write), pop (row pop this
// cycle), rptr (shared read pointer), head (entry at rptr), full, empty.
module col_fifo
  import ofifo_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH,
  localparam int pw     = ptr_w(depth)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [psum_bw-1:0] data,
  input  logic               pop,
  input  logic [pw-1:0]      rptr,
  output logic [psum_bw-1:0] head,
  output logic               full,
  output logic               empty
);
  logic [pw-1:0]      wptr;
  logic [psum_bw-1:0] mem [depth];
  logic               accept;

  assign empty = (wptr == rptr);
  assign full  = (wptr[pw-1] != rptr[pw-1]) && (wptr[pw-2:0] == rptr[pw-2:0]);
  // A pop this cycle frees the slot, so a full column may still take a write.
  // When full, the write slot equals the read slot; head is read before the
  // edge, so the popped row sees the old entry.
  assign accept = wr && (!full || pop);
  assign head   = mem[rptr[pw-2:0]];

  always_ff @(posedge clk) begin
    if (reset)       wptr <= '0;
    else if (accept) wptr <= wptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wptr[pw-2:0]] <= data;
  end
endmodule

// File: rtl/ofifo.sv
// ofifo: output FIFO bank between MAC array columns and the SFU bank.
// Buffers skewed per-column partial sums and releases aligned rows.
// Ports: clk, reset (sync, active high), bus (ofifo_if.slave):
//   wr/in per-column writes, rd row pop, out/out_valid registered row,
//   o_valid (row poppable), o_full (any column full), o_ready (~o_full),
//   o_overflow (sticky dropped-write flag).
// Optional: OFIFO_OVERFLOW_CHK_EN compiles the sticky overflow detector;
// without it o_overflow is tied low (dropping behaviour is identical).
module ofifo
  import ofifo_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH,
  localparam int pw     = ptr_w(depth)
) (
  input  logic    clk,
  input  logic    reset,
  ofifo_if.slave  bus
);
  logic [pw-1:0]               rptr;
  logic [col-1:0]              full;
  logic [col-1:0]              empty;
  logic [col-1:0][psum_bw-1:0] head;
  logic                        pop;

  for (genvar g = 0; g < col; g++) begin : g_col
    col_fifo #(.psum_bw(psum_bw), .depth(depth)) u_col (
      .clk   (clk),
      .reset (reset),
      .wr    (bus.wr[g]),
      .data  (bus.in[g]),
      .pop   (pop),
      .rptr  (rptr),
      .head  (head[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  assign bus.o_valid = ~|empty;
  assign bus.o_full  = |full;
  assign bus.o_ready = ~bus.o_full;
  assign pop         = bus.rd && bus.o_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr          <= '0;
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= pop;
      if (pop) begin
        rptr    <= rptr + 1'b1;
        bus.out <= head;
      end
    end
  end

`ifdef OFIFO_OVERFLOW_CHK_EN
  logic ovf;
  always_ff @(posedge clk) begin
    if (reset) ovf <= 1'b0;
    else if (|(bus.wr & full & ~{col{pop}})) ovf <= 1'b1;
  end
  assign bus.o_overflow = ovf;
`else
  assign bus.o_overflow = 1'b0;
`endif
endmodule

// File: doc/ofifo.md
# ofifo

Output FIFO bank between the MAC array columns and the SFU bank. Each column's partial sums arrive independently, possibly skewed in time. The block buffers them per column and releases one full row of `col` partial sums at a time, aligned across all columns. It drives the SFU bank's `psum_in` bus together with a one-cycle `valid` strobe.

## Interface
- `col`, 8, number of columns (one FIFO per column)
- `psum_bw`, 32, width of one partial sum
- `depth`, 64, entries per column FIFO; must be a power of 2, minimum 2
- `clk`  input  1  single clock; all state updates on rising edge
- `reset`  input  1  synchronous, active-high
- `wr`  input  col  per-column write strobe; bit i writes `in` slice i
- `in`  input  col*psum_bw  column data; slice i = bits [(i+1)*psum_bw-1 : i*psum_bw]
- `rd`  input  1  pop request for one aligned row
- `out`  output  col*psum_bw  registered row data, same slicing as `in`
- `out_valid`  output  1  one-cycle strobe: `out` holds a newly popped row
- `o_valid`  output  1  every column FIFO is non-empty, so a row is poppable
- `o_full`  output  1  at least one column FIFO is full
- `o_ready`  output  1  no column FIFO is full; equals `~o_full`
- `o_overflow`  output  1  sticky error: a write was dropped

## Operation
- **Occupancy tracking.** Each column FIFO keeps its own write pointer. All columns share one read pointer. Pointers are log2(depth)+1 bits and wrap naturally, so full and empty are distinguished by the MSB.
- **Write.** A write to column i is accepted when `wr[i]` is high and either column i is not full or a pop happens in the same cycle. An accepted write stores the slice at that column's write pointer and increments the pointer.
- **Dropped write.** A write to a full column with no simultaneous pop is dropped and sets `o_overflow` (see Configuration). Other columns in the same cycle are unaffected.
- **Pop.** A pop happens when `rd` is high and `o_valid` is high. It reads every column at the shared read pointer into the `out` register, increments the read pointer, and asserts `out_valid` on the next cycle.
- **Pop while not poppable.** `rd` with `o_valid` low is ignored. `out` holds its value and `out_valid` stays 0. There is no bypass: a write to an empty column cannot be popped in the same cycle.
- **Status flags.** `o_valid`, `o_full` and `o_ready` are combinational from the pointers and reflect state before the current edge.
- **Reset values.** All pointers 0, `out` = 0, `out_valid` = 0, `o_overflow` = 0, `o_valid` = 0, `o_full` = 0, `o_ready` = 1.
- **Reset mid-stream.** Reset discards all stored entries. A pop requested in the reset cycle produces no `out_valid`.

## Timing
- **Write-to-status latency.** A write at edge N makes the entry visible in `o_valid` from cycle N+1.
- **Pop latency.** A pop sampled at edge N drives `out` and `out_valid` from N+1. `out` holds until the next pop.
- **Throughput.** One row per cycle with back-to-back `rd`. Each column sustains one write per cycle, including while full if a pop occurs in the same cycle.
- **Full boundary.** After `depth` accepted writes to column i with no pops, `o_full` = 1 and `o_ready` = 0.
- **Wrap-around.** Data order is preserved across wrap-around of both pointers.

## Configuration
- `OFIFO_OVERFLOW_CHK_EN` defined:
  - `o_overflow` sets on any dropped write.
  - It clears only on `reset`.
- Not defined:
  - Overflow logic is not compiled.
  - `o_overflow` is tied to 0.
  - Dropped-write behaviour (data discarded, pointer held) is unchanged.

## Structure
- **Shared package.** Holds default `col`, `psum_bw` and `depth`, plus the pointer-width constant clog2(depth)+1, so that `ofifo`, `sfu_bank` and the core top agree.
- **Sub-module `col_fifo`.**
  - One column: storage array, write pointer, and full/empty computed from an externally supplied shared read pointer.
  - `ofifo` instantiates `col` copies in a generate loop.
  - `ofifo` owns the shared read pointer, the `out` register and the flag reduction.

## Test plan
- **Reset and single row.** Reset, then write 0x11..0x88 to all columns in one cycle, then `rd`. Expect `o_valid` = 1 one cycle after the write, then `out` = {0x88..0x11} with `out_valid` = 1 for exactly one cycle.
- **Skewed arrival.** Column i writes i+1 at cycle i. Expect `o_valid` low until the cycle after column 7 writes. `rd` asserted earlier is ignored with `out_valid` = 0.
- **Full and simultaneous events.** With `depth` = 4, fill column 0 with 4 writes and others with 1, so `o_full` = 1 and `o_ready` = 0. Then:
  - A 5th write with no pop is dropped and `o_overflow` = 1 (with the macro).
  - A write with a simultaneous pop is accepted and order is preserved.
- **Wrap-around stream.** Stream 3×depth rows of incrementing values with `wr` and `rd` every cycle. Expect all values out in order, no overflow, and `out_valid` continuous after the initial latency.
- **Reset mid-operation.** With 3 rows buffered, assert `reset` together with `rd`. Expect no `out_valid`, `o_valid` = 0, `out` = 0 and `o_overflow` cleared.
- **Macro off.** Repeat the full-and-simultaneous-events scenario without `OFIFO_OVERFLOW_CHK_EN`. Expect `o_overflow` stuck at 0 and identical data behaviour.
